// File: rtl/seg_pkg.sv
// seg_pkg: shared types and constants for the 7-segment capture slice.
// Segment bit positions, the hex glyph table and the capture FSM states.
package seg_pkg;

  localparam int SEG_A  = 0;
  localparam int SEG_B  = 1;
  localparam int SEG_C  = 2;
  localparam int SEG_D  = 3;
  localparam int SEG_E  = 4;
  localparam int SEG_F  = 5;
  localparam int SEG_G  = 6;
  localparam int SEG_DP = 7;

  typedef logic [7:0] seg_t;
  typedef logic [3:0] nib_t;

  // Active-high glyphs for 0..F, indexed by the value they show
  localparam logic [6:0] SEG_PAT [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F,
    7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C,
    7'h39, 7'h5E, 7'h79, 7'h71
  };

  typedef enum logic [1:0] {
    IDLE,
    TRACK,
    HELD
  } state_t;

endpackage

// File: rtl/seg_pattern_enc.sv
// seg_pattern_enc: combinational glyph lookup, seg[6:0] -> hit/blank/value.
// Only exact glyph matches count as hits.
module seg_pattern_enc
  import seg_pkg::*;
(
  input  logic [6:0] seg,
  output logic       hit,
  output logic       blank,
  output nib_t       val
);

  always_comb begin
    hit = 1'b0;
    val = '0;
    for (int i = 0; i < 16; i++) begin
      if (seg == SEG_PAT[i]) begin
        hit = 1'b1;
        val = nib_t'(i);
      end
    end
  end

  assign blank = (seg == 7'h00);

endmodule

// File: rtl/seg_scan_capture.sv
// seg_scan_capture: recovers hex digits from a multiplexed 7-seg bus.
// Build with SEG_ERR_CNT_EN to add the err_clr input and err_cnt output.
module seg_scan_capture
  import seg_pkg::*;
#(
  parameter int NDIG       = 4,
  parameter int STABLE_CYC = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  seg_t              seg,
  input  logic [NDIG-1:0]   an,
  output logic [4*NDIG-1:0] hex,
  output logic [NDIG-1:0]   dp,
  output logic [NDIG-1:0]   dig_valid,
  output logic              upd,
  output logic [2:0]        upd_idx,
  output logic              err
`ifdef SEG_ERR_CNT_EN
  ,
  input  logic              err_clr,
  output logic [7:0]        err_cnt
`endif
);

  localparam logic [7:0] CNT_MAX = 8'(STABLE_CYC - 1);

  logic [NDIG-1:0] s_an;
  seg_t            s_seg;
  logic [7:0]      cnt;
  state_t          state;
  state_t          state_n;
  logic            cap;
  logic            onehot;
  logic            hit;
  logic            blank;
  nib_t            val;
  logic [2:0]      idx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_an  <= '0;
      s_seg <= '0;
      cnt   <= '0;
    end else begin
      s_an  <= an;
      s_seg <= seg;
      if ({an, seg} != {s_an, s_seg}) begin
        cnt <= '0;
      end else if (cnt != CNT_MAX) begin
        cnt <= cnt + 8'd1;
      end
    end
  end

  assign onehot = $onehot(s_an);

  always_comb begin
    idx = '0;
    for (int i = 0; i < NDIG; i++) begin
      if (s_an[i]) idx = 3'(i);
    end
  end

  seg_pattern_enc u_enc (
    .seg   (s_seg[SEG_G:SEG_A]),
    .hit   (hit),
    .blank (blank),
    .val   (val)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  // cnt can only be 0 in HELD after the sample moved
  always_comb begin
    state_n = state;
    cap     = 1'b0;
    unique case (state)
      IDLE: begin
        if (onehot) state_n = TRACK;
      end
      TRACK: begin
        if (!onehot) begin
          state_n = IDLE;
        end else if (cnt == CNT_MAX) begin
          cap     = 1'b1;
          state_n = HELD;
        end
      end
      HELD: begin
        if (!onehot)          state_n = IDLE;
        else if (cnt == 8'd0) state_n = TRACK;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hex       <= '0;
      dp        <= '0;
      dig_valid <= '0;
      upd       <= 1'b0;
      upd_idx   <= '0;
      err       <= 1'b0;
    end else begin
      upd <= cap && (hit || blank);
      err <= cap && !hit && !blank;
      if (cap && (hit || blank)) upd_idx <= idx;
      for (int i = 0; i < NDIG; i++) begin
        if (cap && s_an[i]) begin
          if (hit)          hex[4*i +: 4] <= val;
          if (hit || blank) dp[i]         <= s_seg[SEG_DP];
          dig_valid[i] <= hit;
        end
      end
    end
  end

`ifdef SEG_ERR_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt <= '0;
    end else if (err_clr) begin
      err_cnt <= '0;
    end else if (err && err_cnt != 8'hFF) begin
      err_cnt <= err_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_seg_scan_capture.sv
// tb_seg_scan_capture: scoreboard bench for seg_scan_capture.
// A run-length reference model queues expected captures; a monitor checks them.
module tb_seg_scan_capture;

  localparam int NDIG = 4;
  localparam int S    = 4;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  seg   = '0;
  logic [3:0]  an    = '0;
  logic [15:0] hex;
  logic [3:0]  dp;
  logic [3:0]  dig_valid;
  logic        upd;
  logic [2:0]  upd_idx;
  logic        err;
`ifdef SEG_ERR_CNT_EN
  logic        err_clr = 1'b0;
  logic [7:0]  err_cnt;
`endif

  seg_scan_capture #(
    .NDIG       (NDIG),
    .STABLE_CYC (S)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .seg       (seg),
    .an        (an),
    .hex       (hex),
    .dp        (dp),
    .dig_valid (dig_valid),
    .upd       (upd),
    .upd_idx   (upd_idx),
    .err       (err)
`ifdef SEG_ERR_CNT_EN
    ,
    .err_clr   (err_clr),
    .err_cnt   (err_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    bit          is_err;
    int          idx;
    logic [15:0] hex;
    logic [3:0]  dp;
    logic [3:0]  vld;
  } ev_t;

  ev_t q[$];

  logic [6:0] pat [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  int          ncmp = 0;
  int          nerr = 0;
  int          cyc  = 0;
  int          run  = 0;
  bit          have_prev = 0;
  logic [11:0] prev = '0;
  logic [15:0] m_hex = '0;
  logic [3:0]  m_dp  = '0;
  logic [3:0]  m_vld = '0;
  int          m_errs = 0;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h, expected %0h (cyc %0d)",
               name, act, exp, cyc);
    end
  endtask

  // Reference: a capture happens once a one-hot pattern has been
  // sampled on S consecutive edges; it shows up on the next edge.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run       = 0;
      have_prev = 0;
      q.delete();
      m_hex     = '0;
      m_dp      = '0;
      m_vld     = '0;
    end else begin
      cyc++;
      if (have_prev && {an, seg} == prev) run++;
      else run = 1;
      prev      = {an, seg};
      have_prev = 1;
      if (run == S && $countones(an) == 1) begin
        ev_t e;
        int  d;
        int  i;
        d = -1;
        i = 0;
        for (int k = 0; k < NDIG; k++) if (an[k]) i = k;
        for (int k = 0; k < 16; k++) if (seg[6:0] == pat[k]) d = k;
        e.is_err = 0;
        if (d >= 0) begin
          m_hex[4*i +: 4] = 4'(d);
          m_dp[i]  = seg[7];
          m_vld[i] = 1'b1;
        end else if (seg[6:0] == 7'h00) begin
          m_dp[i]  = seg[7];
          m_vld[i] = 1'b0;
        end else begin
          m_vld[i] = 1'b0;
          e.is_err = 1;
          if (m_errs < 255) m_errs++;
        end
        e.cyc = cyc + 1;
        e.idx = i;
        e.hex = m_hex;
        e.dp  = m_dp;
        e.vld = m_vld;
        q.push_back(e);
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (upd && err) chk("upd_err_overlap", 1, 0);
      while (q.size() > 0 && q[0].cyc < cyc) begin
        ncmp++;
        nerr++;
        $display("FAIL missed_event: no upd/err, expected idx %0d at cyc %0d",
                 q[0].idx, q[0].cyc);
        void'(q.pop_front());
      end
      if (upd || err) begin
        if (q.size() == 0) begin
          ncmp++;
          nerr++;
          $display("FAIL unexpected_event: upd=%0b err=%0b, expected none (cyc %0d)",
                   upd, err, cyc);
        end else begin
          ev_t e;
          e = q.pop_front();
          chk("ev_cycle", cyc, e.cyc);
          chk("ev_err", err, e.is_err);
          chk("ev_upd", upd, !e.is_err);
          if (!e.is_err) chk("upd_idx", upd_idx, e.idx);
          chk("ev_hex", hex, e.hex);
          chk("ev_dp", dp, e.dp);
          chk("ev_valid", dig_valid, e.vld);
        end
      end
    end
  end

  task automatic drive(input logic [3:0] a,
                       input logic [7:0] s,
                       input int n);
    @(posedge clk);
    #2;
    an  = a;
    seg = s;
    repeat (n - 1) @(posedge clk);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_hex"}, hex, 0);
    chk({tag, "_dp"}, dp, 0);
    chk({tag, "_valid"}, dig_valid, 0);
    chk({tag, "_upd"}, upd, 0);
    chk({tag, "_idx"}, upd_idx, 0);
    chk({tag, "_err"}, err, 0);
  endtask

  logic [7:0] scan [4] = '{8'h06, 8'h5B, 8'hCF, 8'h71};

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk_zero("reset");
    @(posedge clk);
    #3 rst_n = 1'b1;

    drive(4'b0001, 8'h3F, 6);
    for (int d = 0; d < 4; d++) drive(4'(1 << d), scan[d], 8);
    drive(4'b0000, 8'h00, 2);
    @(negedge clk);
    chk("scan_hex", hex, 16'hF321);
    chk("scan_dp", dp, 4'b0100);
    chk("scan_valid", dig_valid, 4'hF);

    for (int k = 0; k < 5; k++) begin
      drive(4'b0010, 8'h06, 2);
      drive(4'b0010, 8'h07, 2);
    end
    drive(4'b0100, 8'h12, 6);
    drive(4'b0011, 8'h3F, 10);
    drive(4'b0000, 8'h00, 4);
    @(negedge clk);
    chk("ghost_hex", hex, 16'hF321);
    chk("err_valid", dig_valid, 4'b1011);

    drive(4'b1000, 8'h5B, 3);
    #1 rst_n = 1'b0;
    #1 chk_zero("midrst");
    @(posedge clk);
    #3 rst_n = 1'b1;
    repeat (S + 2) @(posedge clk);

    for (int k = 0; k < 300; k++) begin
      logic [3:0] a;
      logic [7:0] s;
      int         r;
      r = int'($urandom_range(0, 9));
      if (r < 8) a = 4'(1 << $urandom_range(0, 3));
      else       a = 4'($urandom);
      r = int'($urandom_range(0, 9));
      if (r < 6)      s = {1'($urandom), pat[$urandom_range(0, 15)]};
      else if (r < 8) s = {1'($urandom), 7'h00};
      else            s = 8'($urandom);
      drive(a, s, int'($urandom_range(1, 7)));
    end

    drive(4'b0000, 8'h00, S + 3);
    @(negedge clk);
    chk("final_hex", hex, m_hex);
    chk("final_dp", dp, m_dp);
    chk("final_valid", dig_valid, m_vld);
    chk("final_pending", q.size(), 0);
`ifdef SEG_ERR_CNT_EN
    chk("final_err_cnt", err_cnt, m_errs);
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
